// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
// Holds the FSM state enum, default geometry and address-field extractors.
package dcache_pkg;

    localparam int DATA_W            = 32;
    localparam int BYTE_OFF_W        = 2;
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 2;
    localparam int DEF_LINE_W        = DATA_W << DEF_LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWAP_OUT,
        S_SWAP_IN,
        S_SWAP_IN_OK
    } state_t;

    // Field extractors return zero-extended values; callers size-cast.
    function automatic logic [31:0] f_word_idx(input logic [31:0] a,
                                               input int line_len);
        return (a >> BYTE_OFF_W) & ((32'd1 << line_len) - 32'd1);
    endfunction

    function automatic logic [31:0] f_set_idx(input logic [31:0] a,
                                              input int line_len,
                                              input int set_len);
        return (a >> (BYTE_OFF_W + line_len)) & ((32'd1 << set_len) - 32'd1);
    endfunction

    function automatic logic [31:0] f_tag(input logic [31:0] a,
                                          input int line_len,
                                          input int set_len);
        return a >> (BYTE_OFF_W + line_len + set_len);
    endfunction

endpackage

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Ports: clk/rst; CPU side rd_req, wr_req, addr, wr_data, rd_data, miss;
// memory side mem_rd_req, mem_wr_req, mem_addr, mem_wr_line, mem_rd_line,
// mem_gnt; statistics hit_cnt, miss_cnt.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_req,
    input  logic                            wr_req,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     wr_data,
    output logic [31:0]                     rd_data,
    output logic                            miss,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [31:0]                     mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                            mem_gnt,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt
);

    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam int LINE_W       = 32 << LINE_ADDR_LEN;
    localparam int OFF_W        = LINE_ADDR_LEN + 2;

    state_t                    r_state;
    state_t                    w_next;
    logic [SETS-1:0]           r_valid;
    logic [SETS-1:0]           r_dirty;
    logic [TAG_ADDR_LEN-1:0]   r_tag  [SETS];
    logic [31:0]               r_data [SETS][LINE_WORDS];
    logic [LINE_W-1:0]         r_fill;
    logic [SET_ADDR_LEN-1:0]   r_mset;
    logic [TAG_ADDR_LEN-1:0]   r_mtag;
    logic [31:0]               r_hit_cnt;
    logic [31:0]               r_miss_cnt;

    logic [LINE_ADDR_LEN-1:0]  w_word;
    logic [SET_ADDR_LEN-1:0]   w_set;
    logic [TAG_ADDR_LEN-1:0]   w_tag;
    logic                      w_req;
    logic                      w_hit;
    logic                      w_idle;
    logic                      w_store;
    logic                      w_leave;

    assign w_word  = LINE_ADDR_LEN'(f_word_idx(addr, LINE_ADDR_LEN));
    assign w_set   = SET_ADDR_LEN'(f_set_idx(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign w_tag   = TAG_ADDR_LEN'(f_tag(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign w_req   = rd_req | wr_req;
    assign w_hit   = w_req && r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_idle  = (r_state == S_IDLE);
    assign w_store = w_idle && wr_req && w_hit;

    assign rd_data  = r_data[w_set][w_word];
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // Victim line is always presented for the latched miss set; it is
    // only consumed while mem_wr_req is high.
    always_comb begin
        mem_wr_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            mem_wr_line[i*32 +: 32] = r_data[r_mset][i];
        end
    end

    always_comb begin
        w_next     = r_state;
        miss       = 1'b0;
        w_leave    = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    miss    = 1'b1;
                    w_leave = 1'b1;
                    if (r_valid[w_set] && r_dirty[w_set]) begin
                        w_next = S_SWAP_OUT;
                    end else begin
                        w_next = S_SWAP_IN;
                    end
                end
            end
            S_SWAP_OUT: begin
                miss       = 1'b1;
                mem_wr_req = 1'b1;
                mem_addr   = {r_tag[r_mset], r_mset, {OFF_W{1'b0}}};
                if (mem_gnt) begin
                    w_next = S_SWAP_IN;
                end
            end
            S_SWAP_IN: begin
                miss       = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {r_mtag, r_mset, {OFF_W{1'b0}}};
                if (mem_gnt) begin
                    w_next = S_SWAP_IN_OK;
                end
            end
            S_SWAP_IN_OK: begin
                miss   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Control state. The miss address is latched on leaving IDLE so the
    // fill completes correctly even if the request changes or drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_mset     <= '0;
            r_mtag     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_leave) begin
                r_mset     <= w_set;
                r_mtag     <= w_tag;
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_idle && w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_store) begin
                r_dirty[w_set] <= 1'b1;
            end
            if (r_state == S_SWAP_IN_OK) begin
                r_valid[r_mset] <= 1'b1;
                r_dirty[r_mset] <= 1'b0;
            end
        end
    end

    // Tag/data arrays and the fill buffer carry no reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_data[w_set][w_word] <= wr_data;
        end
        if (r_state == S_SWAP_IN && mem_gnt) begin
            r_fill <= mem_rd_line;
        end
        if (r_state == S_SWAP_IN_OK) begin
            r_tag[r_mset] <= r_mtag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_data[r_mset][i] <= r_fill[i*32 +: 32];
            end
        end
    end

endmodule
